// File: rtl/async_fifo_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_ptr_sync
// Brief    : Gray-coded FIFO pointer synchronizer with registered binary view,
//            update strobe and sticky multi-bit-step error flag.
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_ptr_sync #(
    parameter int PTR_W    = 5,
    parameter int FLOP_CNT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PTR_W-1:0] gray_in,
    input  logic             clr_err,
    output logic [PTR_W-1:0] gray_sync,
    output logic [PTR_W-1:0] bin_sync,
    output logic             ptr_update,
    output logic             multi_bit_err
);

`ifdef ASSERT_ON
    generate
        if (FLOP_CNT < 2 || FLOP_CNT > 4) begin : g_bad_flop_cnt
            $error("async_fifo_ptr_sync: FLOP_CNT must be 2, 3 or 4");
        end
        if (PTR_W < 2 || PTR_W > 16) begin : g_bad_ptr_w
            $error("async_fifo_ptr_sync: PTR_W must be within 2..16");
        end
    endgenerate
`endif

    localparam logic [PTR_W-1:0] c_one = PTR_W'(1);

    logic [PTR_W-1:0] r_rank [FLOP_CNT];
    logic [PTR_W-1:0] r_gray_q;
    logic [PTR_W-1:0] w_diff;
    logic             w_multi;

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int k = PTR_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Pure flop chain: only rank 0 may go metastable, nothing reconverges before the last rank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FLOP_CNT; i++) begin
                r_rank[i] <= '0;
            end
        end else begin
            r_rank[0] <= gray_in;
            for (int i = 1; i < FLOP_CNT; i++) begin
                r_rank[i] <= r_rank[i-1];
            end
        end
    end

    assign gray_sync = r_rank[FLOP_CNT-1];

    // More than one bit set in the step is detected by clearing the lowest set bit.
    assign w_diff  = gray_sync ^ r_gray_q;
    assign w_multi = ((w_diff & (w_diff - c_one)) != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gray_q      <= '0;
            bin_sync      <= '0;
            ptr_update    <= 1'b0;
            multi_bit_err <= 1'b0;
        end else begin
            r_gray_q   <= gray_sync;
            bin_sync   <= gray2bin(gray_sync);
            ptr_update <= (w_diff != '0);
            if (w_multi) begin
                multi_bit_err <= 1'b1;
            end else if (clr_err) begin
                multi_bit_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo_ptr_sync
// Brief    : Self-checking bench for async_fifo_ptr_sync, FLOP_CNT 2/3/4 side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_ptr_sync;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] gray_in = 4'h0;
    logic       clr_err = 1'b0;

    logic [3:0] gs [3];
    logic [3:0] bs [3];
    logic       up [3];
    logic       er [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        async_fifo_ptr_sync #(.PTR_W(4), .FLOP_CNT(k + 2)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .gray_in      (gray_in),
            .clr_err      (clr_err),
            .gray_sync    (gs[k]),
            .bin_sync     (bs[k]),
            .ptr_update   (up[k]),
            .multi_bit_err(er[k])
        );
    end

    // Reference model: every sample taken since reset release, indexed by edge number.
    logic [3:0] hist [$];
    logic [3:0] m_gs [3];
    logic [3:0] m_bs [3];
    logic       m_up [3];
    logic       m_er [3];
    int         m_n;
    int         m_f;
    logic [3:0] m_cur;
    logic [3:0] m_prv;

    function automatic logic [3:0] sampled(input int m);
        if (m >= 1 && m <= hist.size()) return hist[m-1];
        return 4'h0;
    endfunction

    function automatic logic [3:0] to_bin(input logic [3:0] g);
        for (int b = 0; b < 16; b++) begin
            if (4'(b ^ (b >> 1)) == g) return 4'(b);
        end
        return 4'h0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            for (int k = 0; k < 3; k++) begin
                m_gs[k] = 4'h0;
                m_bs[k] = 4'h0;
                m_up[k] = 1'b0;
                m_er[k] = 1'b0;
            end
        end else begin
            hist.push_back(gray_in);
            m_n = hist.size();
            for (int k = 0; k < 3; k++) begin
                m_f     = k + 2;
                m_cur   = sampled(m_n - m_f);
                m_prv   = sampled(m_n - m_f - 1);
                m_gs[k] = sampled(m_n - m_f + 1);
                m_bs[k] = to_bin(m_cur);
                m_up[k] = (m_cur != m_prv);
                if ($countones(m_cur ^ m_prv) > 1) m_er[k] = 1'b1;
                else if (clr_err)                  m_er[k] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
    } vec_t;

    vec_t       sweep [17];
    logic       rec_up [1:8];
    logic [3:0] rec_bs [1:8];
    int         lat [3];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         pulses;
        int         run;
        logic [3:0] b;
        int         r;

        sweep = '{'{4'h0, 4'h0}, '{4'h1, 4'h1}, '{4'h3, 4'h2}, '{4'h2, 4'h3},
                  '{4'h6, 4'h4}, '{4'h7, 4'h5}, '{4'h5, 4'h6}, '{4'h4, 4'h7},
                  '{4'hC, 4'h8}, '{4'hD, 4'h9}, '{4'hF, 4'hA}, '{4'hE, 4'hB},
                  '{4'hA, 4'hC}, '{4'hB, 4'hD}, '{4'h9, 4'hE}, '{4'h8, 4'hF},
                  '{4'h0, 4'h0}};

        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("sb_gray_sync_f%0d", k + 2), 16'(gs[k]), 16'(m_gs[k]));
                    chk($sformatf("sb_bin_sync_f%0d", k + 2), 16'(bs[k]), 16'(m_bs[k]));
                    chk($sformatf("sb_ptr_update_f%0d", k + 2), 16'(up[k]), 16'(m_up[k]));
                    chk($sformatf("sb_multi_bit_err_f%0d", k + 2), 16'(er[k]), 16'(m_er[k]));
                end
            end
        join_none

        // Reset held with a non-zero source pointer
        #1;
        reset_n = 1'b0;
        gray_in = 4'hC;
        repeat (3) tick();
        chk("rst_gray_sync", 16'(gs[0]), 16'h0);
        chk("rst_bin_sync", 16'(bs[0]), 16'h0);
        chk("rst_ptr_update", 16'(up[0]), 16'h0);
        chk("rst_err", 16'(er[0]), 16'h0);
        reset_n = 1'b1;
        pulses = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (up[0]) pulses++;
            if (t == 1) chk("rel_gray_sync_e1", 16'(gs[0]), 16'h0);
            if (t == 2) chk("rel_gray_sync_e2", 16'(gs[0]), 16'hC);
            if (t == 2) chk("rel_bin_sync_e2", 16'(bs[0]), 16'h0);
            if (t == 3) chk("rel_bin_sync_e3", 16'(bs[0]), 16'h8);
            if (t == 3) chk("rel_err_e3", 16'(er[0]), 16'h1);
        end
        chk("rel_update_pulses", 16'(pulses), 16'h1);

        gray_in = 4'h0;
        repeat (6) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        for (int k = 0; k < 3; k++) chk($sformatf("clr_err_f%0d", k + 2), 16'(er[k]), 16'h0);

        // Increment sweep including the 8 -> 0 wrap, one value every 4 clocks
        for (int i = 1; i < 17; i++) begin
            gray_in = sweep[i].gray;
            pulses  = 0;
            for (int t = 1; t <= 4; t++) begin
                tick();
                if (up[0]) pulses++;
                if (t == 2) chk($sformatf("sweep_hold_%0d", i), 16'(bs[0]), 16'(sweep[i-1].bin));
                if (t == 3) chk($sformatf("sweep_bin_%0d", i), 16'(bs[0]), 16'(sweep[i].bin));
                if (t == 3) chk($sformatf("sweep_err_%0d", i), 16'(er[0]), 16'h0);
            end
            chk($sformatf("sweep_pulses_%0d", i), 16'(pulses), 16'h1);
        end
        repeat (6) tick();
        for (int k = 0; k < 3; k++) chk($sformatf("sweep_no_err_f%0d", k + 2), 16'(er[k]), 16'h0);

        // Latency per build: gray_in change to bin_sync update
        for (int k = 0; k < 3; k++) lat[k] = 0;
        gray_in = 4'h1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            for (int k = 0; k < 3; k++) if (lat[k] == 0 && bs[k] == 4'h1) lat[k] = t;
        end
        for (int k = 0; k < 3; k++) chk($sformatf("latency_f%0d", k + 2), 16'(lat[k]), 16'(k + 3));

        // Back-to-back increments through binary 3..7
        gray_in = 4'h3;
        repeat (6) tick();
        gray_in = 4'h2;
        repeat (6) tick();
        gray_in = 4'h6;
        for (int t = 1; t <= 8; t++) begin
            tick();
            rec_up[t] = up[0];
            rec_bs[t] = bs[0];
            if (t == 1) gray_in = 4'h7;
            else if (t == 2) gray_in = 4'h5;
            else if (t == 3) gray_in = 4'h4;
        end
        run = 0;
        for (int t = 1; t <= 8; t++) if (rec_up[t]) run++;
        chk("b2b_update_count", 16'(run), 16'h4);
        for (int t = 3; t <= 6; t++) begin
            chk($sformatf("b2b_update_t%0d", t), 16'(rec_up[t]), 16'h1);
            chk($sformatf("b2b_bin_t%0d", t), 16'(rec_bs[t]), 16'(t + 1));
        end
        chk("b2b_err", 16'(er[0]), 16'h0);

        // Walk back down to binary 3 with single-bit steps, then violate
        gray_in = 4'h5; repeat (2) tick();
        gray_in = 4'h7; repeat (2) tick();
        gray_in = 4'h6; repeat (2) tick();
        gray_in = 4'h2; repeat (6) tick();
        chk("viol_pre_err", 16'(er[0]), 16'h0);
        gray_in = 4'h5;
        tick();
        tick();
        chk("viol_err_lat2", 16'(er[0]), 16'h0);
        tick();
        chk("viol_err_lat3", 16'(er[0]), 16'h1);
        chk("viol_bin", 16'(bs[0]), 16'h6);
        repeat (4) tick();
        chk("viol_sticky", 16'(er[0]), 16'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("viol_cleared", 16'(er[0]), 16'h0);
        tick();
        chk("viol_stays_clear", 16'(er[0]), 16'h0);

        // Clear coinciding with a fresh violation: the set wins
        gray_in = 4'h2;
        tick();
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("set_beats_clear", 16'(er[0]), 16'h1);
        tick();
        chk("set_beats_clear_hold", 16'(er[0]), 16'h1);
        repeat (4) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        for (int k = 0; k < 3; k++) chk($sformatf("final_clear_f%0d", k + 2), 16'(er[k]), 16'h0);

        // Asynchronous reset between edges with a value in flight
        gray_in = 4'h6;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        gray_in = 4'h0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst_gray_f%0d", k + 2), 16'(gs[k]), 16'h0);
            chk($sformatf("midrst_bin_f%0d", k + 2), 16'(bs[k]), 16'h0);
            chk($sformatf("midrst_upd_f%0d", k + 2), 16'(up[k]), 16'h0);
            chk($sformatf("midrst_err_f%0d", k + 2), 16'(er[k]), 16'h0);
        end
        #2;
        reset_n = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk($sformatf("post_rst_gray_t%0d", t), 16'(gs[2]), 16'h0);
            chk($sformatf("post_rst_upd_t%0d", t), 16'(up[2]), 16'h0);
        end

        // Randomized walk with occasional jumps and clears
        b = 4'h0;
        repeat (400) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = b + 4'h1;
            else if (r < 80) b = b - 4'h1;
            else if (r < 90) b = b;
            else             b = 4'($urandom);
            gray_in = b ^ (b >> 1);
            clr_err = ($urandom_range(0, 7) == 0);
            tick();
        end
        clr_err = 1'b0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/async_fifo_ptr_sync.md
# async_fifo_ptr_sync

Parametrised multi-bit synchronizer for Gray-coded async FIFO pointers, with a configurable flop-chain depth. It sits in the destination clock domain of the async FIFO (write pointer into read domain, read pointer into write domain). It delivers the synchronized Gray value, its registered binary equivalent and a one-cycle update strobe. It also monitors the Gray-code invariant, at most one bit change per sampled step, and raises a sticky error when that invariant is violated.

## Interface
- PTR_W, default 5: pointer width in bits (FIFO address width + 1 wrap bit); legal range 2..16.
- FLOP_CNT, default 2: synchronizer depth in flops; legal values 2, 3, 4. Any other value is an elaboration error (assertion under ASSERT_ON).

- clk  input  1  destination-domain clock.
- reset_n  input  1  asynchronous, active-low reset.
- gray_in  input  PTR_W  Gray-coded pointer from the source domain; asynchronous to clk.
- clr_err  input  1  synchronous clear of multi_bit_err.
- gray_sync  output  PTR_W  last stage of the synchronizer chain.
- bin_sync  output  PTR_W  registered Gray-to-binary conversion of gray_sync.
- ptr_update  output  1  one-cycle strobe; bin_sync took a new value this cycle.
- multi_bit_err  output  1  sticky flag; a sampled step changed more than one bit.

## Operation
- Synchronizer chain: FLOP_CNT ranks, each PTR_W wide, all on posedge clk with async reset.
  - Rank 0 samples gray_in.
  - Rank i samples rank i-1.
  - gray_sync is the last rank.
  - No logic between ranks.
- Each clock edge, the history stage registers the following simultaneously:
  - gray_q <= gray_sync (internal, one cycle older copy).
  - bin_sync <= gray2bin(gray_sync). Bit PTR_W-1 equals g[PTR_W-1]; bit k equals bin[k+1] XOR g[k].
  - ptr_update <= (gray_sync != gray_q).
- Error check, on every edge:
  - d = popcount(gray_sync XOR gray_q).
  - If d > 1, multi_bit_err <= 1.
  - Else if clr_err, multi_bit_err <= 0.
  - Otherwise multi_bit_err holds.
  - Set has priority over clear in the same cycle.
- Wrap-around: gray 100..0 (binary 2^PTR_W-1) to 000..0 is a single-bit change. It is a legal update and raises no error.
- No change (d == 0): ptr_update stays 0 and bin_sync holds its value.
- Reset (reset_n low, at any time including mid-transfer):
  - All ranks, gray_q, bin_sync, ptr_update and multi_bit_err go to 0 immediately.
  - After release, the chain refills from gray_in.
  - If gray_in is non-zero at release, the first propagated value is compared against gray_q = 0. A multi-bit difference sets multi_bit_err. Software/bench must clear it, or the source must also be in reset.

## Timing
- Let edge E be the first edge at which a stable gray_in value is sampled.
  - gray_sync shows it after edge E+FLOP_CNT-1, i.e. FLOP_CNT edges including E.
  - bin_sync, ptr_update and multi_bit_err reflect it after edge E+FLOP_CNT.
- Total latency gray_in to bin_sync: FLOP_CNT+1 cycles.
- Back-to-back source increments, one new Gray value per destination cycle: ptr_update stays high continuously and bin_sync increments by 1 each cycle.
- Source faster than destination: intermediate values may be skipped. A skipped step shows as d > 1 and sets multi_bit_err. This is intended: it flags a clock-ratio violation.
- clr_err acts at the next edge. The flag reads 0 the cycle after, unless a new violation occurs in the same cycle.
- Metastability: only rank 0 may go metastable. No reconvergent logic before the last rank.

## Test plan
All tests use PTR_W=4, FLOP_CNT=2 unless stated.
- Reset: hold reset_n low with gray_in=4'hC. All outputs read 0. Release reset_n, then:
  - gray_sync=4'hC after 2 edges.
  - bin_sync=4'h8 after 3 edges.
  - ptr_update pulses once.
  - multi_bit_err=1 (2-bit step from 0).
- Increment sweep: clear the error, then step gray_in 0,1,3,2,6,…,9,8,0 (binary 0..15, wrap), one value every 4 clocks.
  - bin_sync follows 0..15, then 0, each value 3 cycles after the change.
  - Exactly one ptr_update pulse per step.
  - multi_bit_err stays 0, including at the 8 to 0 wrap.
- Back-to-back: change gray_in every clk through binary 3..7.
  - ptr_update is high for 4 consecutive cycles.
  - bin_sync reads 4,5,6,7 on consecutive cycles.
- Multi-bit violation and clear: jump gray_in from 4'h2 to 4'h5 (3 bits differ).
  - multi_bit_err=1 at latency 3 and stays high.
  - Assert clr_err for 1 cycle: flag reads 0 the next cycle.
  - Repeat with clr_err asserted in the same cycle as a new violation: flag stays 1.
- Reset mid-operation: pulse reset_n low asynchronously between edges while a value is in the chain.
  - All outputs read 0 immediately.
  - No stale value emerges after release.
- FLOP_CNT=3 and 4 builds: rerun the increment sweep.
  - Latency is 4 and 5 cycles respectively.
  - FLOP_CNT=1 or 5 fails elaboration under ASSERT_ON.
